// File: rtl/vga_pkg.sv
// Shared types and defaults for the VGA framebuffer arbiter slice.
package vga_pkg;

  localparam int unsigned DEF_FB_W = 640;
  localparam int unsigned DEF_FB_H = 480;
  localparam int unsigned COORD_W  = 10;
  localparam int unsigned DROP_W   = 16;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } pixel_t;

  // Encoding doubles as {mem_we, mem_en} so the RAM strobes come straight off the state flops.
  typedef enum logic [1:0] {
    G_IDLE  = 2'b00,
    G_READ  = 2'b01,
    G_WRITE = 2'b11
  } grant_e;

  function automatic logic coord_in_range(input logic [COORD_W-1:0] x,
                                          input logic [COORD_W-1:0] y,
                                          input int unsigned        w,
                                          input int unsigned        h);
    return (32'(x) < w) && (32'(y) < h);
  endfunction

endpackage

// File: rtl/vga_wr_fifo.sv
// Synchronous host-write FIFO; full/empty are registered, head is a plain read of the storage.
module vga_wr_fifo #(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = logic [7:0]
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output entry_t head_c,
  output logic   full,
  output logic   empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head_c  = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
      full  <= (count_next == CNT_W'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: scan-out reads have strict priority, host writes
// are queued and drained into slots the scan-out does not use.
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int unsigned FB_W       = DEF_FB_W,
  parameter int unsigned FB_H       = DEF_FB_H,
  parameter int unsigned X_BITS     = 10,
  parameter int unsigned Y_BITS     = 9,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter pixel_t      BORDER     = pixel_t'(24'h000000)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       vga_req,
  input  logic [COORD_W-1:0]         vga_x,
  input  logic [COORD_W-1:0]         vga_y,
  output logic                       vga_valid,
  output pixel_t                     vga_data,
  input  logic                       host_valid,
  output logic                       host_ready,
  input  logic [COORD_W-1:0]         host_x,
  input  logic [COORD_W-1:0]         host_y,
  input  pixel_t                     host_data,
  output logic                       mem_en,
  output logic                       mem_we,
  output logic [X_BITS+Y_BITS-1:0]   mem_addr,
  output pixel_t                     mem_wdata,
  input  pixel_t                     mem_rdata,
  output logic [DROP_W-1:0]          dropped
);

  localparam int unsigned ADDR_W = X_BITS + Y_BITS;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    pixel_t            data;
  } wr_entry_t;

  function automatic logic [ADDR_W-1:0] pack_addr(input logic [COORD_W-1:0] x,
                                                  input logic [COORD_W-1:0] y);
    return {y[Y_BITS-1:0], x[X_BITS-1:0]};
  endfunction

  grant_e            state;
  grant_e            state_next;
  logic [ADDR_W-1:0] mem_addr_next;
  pixel_t            mem_wdata_next;

  logic      vga_in_range_c;
  logic      host_in_range_c;
  logic      host_accept_c;
  logic      push_c;
  logic      pop_c;
  wr_entry_t push_entry_c;
  wr_entry_t head_c;
  logic      fifo_full;
  logic      fifo_empty;

  logic rd_v1;
  logic rd_b1;
  logic rd_v2;
  logic rd_b2;

  assign vga_in_range_c  = coord_in_range(vga_x, vga_y, FB_W, FB_H);
  assign host_in_range_c = coord_in_range(host_x, host_y, FB_W, FB_H);
  assign host_accept_c   = host_valid && host_ready;
  assign push_c          = host_accept_c && host_in_range_c;
  assign push_entry_c    = '{addr: pack_addr(host_x, host_y), data: host_data};
  assign host_ready      = !fifo_full;

  vga_wr_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (wr_entry_t)
  ) u_wr_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_c),
    .push_data (push_entry_c),
    .pop       (pop_c),
    .head_c    (head_c),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Grant decision: in-range scan-out read wins, otherwise drain one queued write.
  always_comb begin
    state_next     = G_IDLE;
    mem_addr_next  = mem_addr;
    mem_wdata_next = mem_wdata;
    pop_c          = 1'b0;
    if (vga_req && vga_in_range_c) begin
      state_next    = G_READ;
      mem_addr_next = pack_addr(vga_x, vga_y);
    end else if (!fifo_empty) begin
      state_next     = G_WRITE;
      mem_addr_next  = head_c.addr;
      mem_wdata_next = head_c.data;
      pop_c          = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= G_IDLE;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_next;
      mem_addr  <= mem_addr_next;
      mem_wdata <= mem_wdata_next;
    end
  end

  assign mem_en = state[0];
  assign mem_we = state[1];

  // Read pipeline: stage 1 aligns with mem_*, stage 2 with mem_rdata, then the output register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_v1     <= 1'b0;
      rd_b1     <= 1'b0;
      rd_v2     <= 1'b0;
      rd_b2     <= 1'b0;
      vga_valid <= 1'b0;
      vga_data  <= '0;
    end else begin
      rd_v1     <= vga_req;
      rd_b1     <= !vga_in_range_c;
      rd_v2     <= rd_v1;
      rd_b2     <= rd_b1;
      vga_valid <= rd_v2;
      if (rd_v2) vga_data <= rd_b2 ? BORDER : mem_rdata;
    end
  end

  // Out-of-range host writes are consumed but only counted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dropped <= '0;
    end else if (host_accept_c && !host_in_range_c && (dropped != {DROP_W{1'b1}})) begin
      dropped <= dropped + DROP_W'(1);
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter with a behavioural single-port RAM model.
module tb_vga_fb_arbiter;
  import vga_pkg::*;

  typedef struct {
    int unsigned due;
    pixel_t      data;
  } rd_exp_t;

  typedef struct {
    logic [18:0] addr;
    pixel_t      data;
  } wr_exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vga_req = 1'b0;
  logic [9:0]  vga_x = '0;
  logic [9:0]  vga_y = '0;
  logic        vga_valid;
  pixel_t      vga_data;
  logic        host_valid = 1'b0;
  logic        host_ready;
  logic [9:0]  host_x = '0;
  logic [9:0]  host_y = '0;
  pixel_t      host_data = '0;
  logic        mem_en;
  logic        mem_we;
  logic [18:0] mem_addr;
  pixel_t      mem_wdata;
  pixel_t      mem_rdata = '0;
  logic [15:0] dropped;

  logic        bd_we = 1'b0;
  logic [18:0] bd_addr = '0;
  pixel_t      bd_data = '0;

  int unsigned cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  rd_exp_t     rd_q[$];
  wr_exp_t     wr_q[$];
  rd_exp_t     rd_e;
  wr_exp_t     wr_e;
  pixel_t      ram [int unsigned];

  localparam pixel_t TB_BORDER = 24'h000000;

  vga_fb_arbiter dut (
    .clock      (clk),
    .reset      (rst_n),
    .vga_req    (vga_req),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_valid  (vga_valid),
    .vga_data   (vga_data),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .host_x     (host_x),
    .host_y     (host_y),
    .host_data  (host_data),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .dropped    (dropped)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [18:0] tb_addr(input logic [9:0] x, input logic [9:0] y);
    return {y[8:0], x};
  endfunction

  function automatic pixel_t default_pix(input logic [18:0] a);
    return pixel_t'({5'h15, a});
  endfunction

  function automatic pixel_t dp(input logic [9:0] x, input logic [9:0] y);
    return default_pix(tb_addr(x, y));
  endfunction

  // Synchronous single-port RAM; unwritten words read back an address-derived pattern.
  always @(posedge clk) begin
    if (bd_we) ram[32'(bd_addr)] = bd_data;
    if (mem_en) begin
      if (mem_we) ram[32'(mem_addr)] = mem_wdata;
      else mem_rdata <= ram.exists(32'(mem_addr)) ? ram[32'(mem_addr)] : default_pix(mem_addr);
    end
  end

  // Output monitor: pops expected reads and writes as the DUT produces them.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_q.size() != 0 && rd_q[0].due == cyc && !vga_valid) begin
        vectors++;
        miscompares++;
        $display("FAIL rd_missing cyc=%0d want %h", cyc, rd_q[0].data);
        void'(rd_q.pop_front());
      end
      if (vga_valid) begin
        vectors++;
        if (rd_q.size() == 0) begin
          miscompares++;
          $display("FAIL rd_stray cyc=%0d got %h want none", cyc, vga_data);
        end else begin
          rd_e = rd_q.pop_front();
          if (rd_e.due !== cyc || vga_data !== rd_e.data) begin
            miscompares++;
            $display("FAIL rd_data cyc=%0d got %h want %h due %0d", cyc, vga_data, rd_e.data, rd_e.due);
          end
        end
      end
      if (mem_en && mem_we) begin
        vectors++;
        if (wr_q.size() == 0) begin
          miscompares++;
          $display("FAIL wr_stray cyc=%0d got addr %h data %h want none", cyc, mem_addr, mem_wdata);
        end else begin
          wr_e = wr_q.pop_front();
          if (mem_addr !== wr_e.addr || mem_wdata !== wr_e.data) begin
            miscompares++;
            $display("FAIL wr_data cyc=%0d got %h/%h want %h/%h", cyc, mem_addr, mem_wdata, wr_e.addr, wr_e.data);
          end
        end
      end
    end
  end

  // One clock of stimulus; expectations are queued as the stimulus is applied.
  task automatic drive_cycle(input logic rq, input logic [9:0] rx, input logic [9:0] ry,
                             input pixel_t rexp, input logic hv, input logic [9:0] hx,
                             input logic [9:0] hy, input pixel_t hd);
    vga_req    = rq;
    vga_x      = rx;
    vga_y      = ry;
    host_valid = hv;
    host_x     = hx;
    host_y     = hy;
    host_data  = hd;
    if (rq) rd_q.push_back('{due: cyc + 3, data: rexp});
    if (hv && host_ready && hx < 10'd640 && hy < 10'd480)
      wr_q.push_back('{addr: tb_addr(hx, hy), data: hd});
    @(posedge clk);
    #1;
    vga_req    = 1'b0;
    host_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #2;
    vectors += 8;
    if (vga_valid !== 1'b0)      begin miscompares++; $display("FAIL rst_vga_valid got %b want 0", vga_valid); end
    if (vga_data !== 24'h0)      begin miscompares++; $display("FAIL rst_vga_data got %h want 0", vga_data); end
    if (host_ready !== 1'b1)     begin miscompares++; $display("FAIL rst_host_ready got %b want 1", host_ready); end
    if (mem_en !== 1'b0)         begin miscompares++; $display("FAIL rst_mem_en got %b want 0", mem_en); end
    if (mem_we !== 1'b0)         begin miscompares++; $display("FAIL rst_mem_we got %b want 0", mem_we); end
    if (mem_addr !== 19'h0)      begin miscompares++; $display("FAIL rst_mem_addr got %h want 0", mem_addr); end
    if (mem_wdata !== 24'h0)     begin miscompares++; $display("FAIL rst_mem_wdata got %h want 0", mem_wdata); end
    if (dropped !== 16'h0)       begin miscompares++; $display("FAIL rst_dropped got %h want 0", dropped); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_read_latency;
    bd_we = 1'b1; bd_addr = '0; bd_data = 24'h112233;
    @(posedge clk);
    #1;
    bd_we = 1'b0;
    drive_cycle(1'b1, 10'd0, 10'd0, 24'h112233, 1'b0, '0, '0, '0);
    vectors++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 19'h0) begin
      miscompares++;
      $display("FAIL rd_grant got en=%b we=%b addr=%h want 1/0/0", mem_en, mem_we, mem_addr);
    end
    idle(5);
    for (int x = 0; x < 640; x++)
      drive_cycle(1'b1, 10'(x), 10'd20, dp(10'(x), 10'd20), 1'b0, '0, '0, '0);
    idle(5);
  endtask

  task automatic test_border;
    drive_cycle(1'b1, 10'd640, 10'd10, TB_BORDER, 1'b0, '0, '0, '0);
    vectors++;
    if (mem_en !== 1'b0) begin miscompares++; $display("FAIL border_no_ram got en=%b want 0", mem_en); end
    drive_cycle(1'b1, 10'd0, 10'd480, TB_BORDER, 1'b0, '0, '0, '0);
    vectors++;
    if (mem_en !== 1'b0) begin miscompares++; $display("FAIL border_y_no_ram got en=%b want 0", mem_en); end
    idle(4);
    drive_cycle(1'b1, 10'd1, 10'd40, dp(10'd1, 10'd40), 1'b1, 10'd3, 10'd200, 24'h0A0B0C);
    drive_cycle(1'b1, 10'd2, 10'd40, dp(10'd2, 10'd40), 1'b0, '0, '0, '0);
    vectors++;
    if (mem_we !== 1'b0) begin miscompares++; $display("FAIL border_pre_we got %b want 0", mem_we); end
    drive_cycle(1'b1, 10'd640, 10'd10, TB_BORDER, 1'b0, '0, '0, '0);
    vectors++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== tb_addr(10'd3, 10'd200)) begin
      miscompares++;
      $display("FAIL border_slot_write got en=%b we=%b addr=%h want 1/1/%h", mem_en, mem_we, mem_addr, tb_addr(10'd3, 10'd200));
    end
    idle(5);
  endtask

  task automatic test_write_drain;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b1, 10'(i), 10'd50, dp(10'(i), 10'd50), 1'b1, 10'(10 + i), 10'd300, pixel_t'(24'hC00000 + i));
      vectors++;
      if (mem_we !== 1'b0) begin miscompares++; $display("FAIL drain_starved_we i=%0d got %b want 0", i, mem_we); end
    end
    vectors++;
    if (host_ready !== 1'b0) begin miscompares++; $display("FAIL drain_full got ready=%b want 0", host_ready); end
    drive_cycle(1'b1, 10'd4, 10'd50, dp(10'd4, 10'd50), 1'b1, 10'd20, 10'd300, 24'hDEAD00);
    drive_cycle(1'b1, 10'd5, 10'd50, dp(10'd5, 10'd50), 1'b0, '0, '0, '0);
    vectors++;
    if (host_ready !== 1'b0 || mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_hold got ready=%b we=%b want 0/0", host_ready, mem_we);
    end
    for (int i = 0; i < 4; i++) begin
      idle(1);
      vectors++;
      if (mem_we !== 1'b1 || host_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL drain_issue i=%0d got we=%b ready=%b want 1/1", i, mem_we, host_ready);
      end
    end
    idle(1);
    vectors++;
    if (mem_en !== 1'b0) begin miscompares++; $display("FAIL drain_done got en=%b want 0", mem_en); end
    idle(4);
  endtask

  task automatic test_dropped;
    drive_cycle(1'b0, '0, '0, '0, 1'b1, 10'd100, 10'd480, 24'h111111);
    drive_cycle(1'b0, '0, '0, '0, 1'b1, 10'd700, 10'd0, 24'h222222);
    idle(3);
    vectors++;
    if (dropped !== 16'd2) begin miscompares++; $display("FAIL dropped_two got %0d want 2", dropped); end
    host_valid = 1'b1; host_x = 10'd700; host_y = 10'd0;
    repeat (65533) @(posedge clk);
    #1;
    host_valid = 1'b0;
    vectors++;
    if (dropped !== 16'hFFFF) begin miscompares++; $display("FAIL dropped_max got %h want ffff", dropped); end
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, '0, '0, '0, 1'b1, 10'd700, 10'd0, '0);
    vectors++;
    if (dropped !== 16'hFFFF || host_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL dropped_sat got %h ready=%b want ffff/1", dropped, host_ready);
    end
    idle(3);
  endtask

  task automatic test_ordering;
    drive_cycle(1'b1, 10'd0, 10'd60, dp(10'd0, 10'd60), 1'b1, 10'd5, 10'd5, 24'hABCDEF);
    drive_cycle(1'b1, 10'd1, 10'd60, dp(10'd1, 10'd60), 1'b0, '0, '0, '0);
    drive_cycle(1'b1, 10'd5, 10'd5, dp(10'd5, 10'd5), 1'b0, '0, '0, '0);
    idle(4);
    drive_cycle(1'b1, 10'd5, 10'd5, 24'hABCDEF, 1'b0, '0, '0, '0);
    idle(5);
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 5; i++)
      drive_cycle(1'b1, 10'(i), 10'd70, dp(10'(i), 10'd70), (i < 3), 10'(30 + i), 10'd310, pixel_t'(24'h3C0000 + i));
    rst_n = 1'b0;
    #1;
    rd_q.delete();
    wr_q.delete();
    vectors += 4;
    if (vga_valid !== 1'b0)  begin miscompares++; $display("FAIL mid_vga_valid got %b want 0", vga_valid); end
    if (mem_en !== 1'b0 || mem_we !== 1'b0) begin miscompares++; $display("FAIL mid_mem got en=%b we=%b want 0/0", mem_en, mem_we); end
    if (host_ready !== 1'b1) begin miscompares++; $display("FAIL mid_host_ready got %b want 1", host_ready); end
    if (mem_addr !== 19'h0 || mem_wdata !== 24'h0 || vga_data !== 24'h0) begin
      miscompares++;
      $display("FAIL mid_regs got addr=%h wdata=%h data=%h want 0", mem_addr, mem_wdata, vga_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle(8);
    vectors++;
    if (mem_en !== 1'b0 || dropped !== 16'h0) begin
      miscompares++;
      $display("FAIL mid_after got en=%b dropped=%h want 0/0", mem_en, dropped);
    end
  endtask

  initial begin
    test_reset;
    test_read_latency;
    test_border;
    test_write_drain;
    test_dropped;
    test_ordering;
    test_reset_mid;
    vectors++;
    if (rd_q.size() != 0 || wr_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover got rd=%0d wr=%0d want 0/0", rd_q.size(), wr_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
